// File: rtl/serial_tx_fifo_if.sv
// serial_tx_fifo_if: bus bundle between producer/transmitter and serial_tx_fifo.
//   Producer side : IN_DATA, IN_WRITE, OUT_FULL, OUT_EMPTY, OUT_COUNT, OUT_OVERFLOW
//   Transmitter   : OUT_TX_DATA, OUT_TX_SEND, IN_TX_READY
//   slave  modport: the FIFO's view (drives OUT_*).
//   master modport: the environment's view (drives IN_*).
interface serial_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_WRITE;
    logic                  OUT_FULL;
    logic                  OUT_EMPTY;
    logic [DEPTH_LOG2:0]   OUT_COUNT;
    logic                  OUT_OVERFLOW;
    logic [DATA_WIDTH-1:0] OUT_TX_DATA;
    logic                  OUT_TX_SEND;
    logic                  IN_TX_READY;

    modport slave (
        input  IN_DATA, IN_WRITE, IN_TX_READY,
        output OUT_FULL, OUT_EMPTY, OUT_COUNT, OUT_OVERFLOW, OUT_TX_DATA, OUT_TX_SEND
    );

    modport master (
        output IN_DATA, IN_WRITE, IN_TX_READY,
        input  OUT_FULL, OUT_EMPTY, OUT_COUNT, OUT_OVERFLOW, OUT_TX_DATA, OUT_TX_SEND
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: byte FIFO plus send sequencer in front of a UART transmitter.
// Producers enqueue bytes at full clock rate; a 3-state FSM pops one byte per
// transmitter frame and issues it over the READY/SEND handshake.
//   CLK   : system clock, rising edge
//   RESET : synchronous, active high
//   bus   : serial_tx_fifo_if.slave (write port, status, transmitter handshake)
module serial_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic              CLK,
    input logic              RESET,
    serial_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_LOW} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_send_q, tx_send_d;

    logic full, empty, wr_en, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        tx_send_d  = 1'b0;
        pop        = 1'b0;
        // Full is judged on the registered count, so a write is dropped even
        // if a pop frees a slot in the same cycle.
        wr_en      = bus.IN_WRITE && !full;
        overflow_d = overflow_q || (bus.IN_WRITE && full);

        case (state_q)
            ST_IDLE: begin
                // empty is from the registered count: a byte written this cycle
                // is not yet visible, so its earliest pop is next cycle.
                if (!empty && bus.IN_TX_READY) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    tx_send_d = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND:     state_d = ST_WAIT_LOW;
            // Transmitter READY lags SEND by a cycle; wait for it to drop so a
            // stale READY cannot trigger a second send.
            ST_WAIT_LOW: if (!bus.IN_TX_READY) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_send_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
        end
    end

    // Storage is not reset; only the pointers define valid contents.
    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) mem_q[wr_ptr_q] <= bus.IN_DATA;
    end

    assign bus.OUT_FULL     = full;
    assign bus.OUT_EMPTY    = empty;
    assign bus.OUT_COUNT    = count_q;
    assign bus.OUT_OVERFLOW = overflow_q;
    assign bus.OUT_TX_DATA  = tx_data_q;
    assign bus.OUT_TX_SEND  = tx_send_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: randomized bench for serial_tx_fifo. A queue-based
// reference model predicts occupancy, flags and send strobes; a small
// transmitter model (READY low for a frame after each accepted SEND) consumes
// bytes and compares them in order against the bytes the model popped.
module tb_serial_tx_fifo;
    logic CLK = 1'b0;
    logic RESET;

    serial_tx_fifo_if #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) bus ();

    serial_tx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int errs   = 0;
    int checks = 0;

    // stimulus controls
    logic       rst, wr, rdy_force;
    logic [7:0] din;
    bit         rdy_mode;      // 0: READY forced to rdy_force, 1: transmitter model
    int         tx_frame;
    int         tx_busy;
    bit         tx_init;

    // reference model state
    logic [7:0] m_q[$];
    logic [7:0] exp_sent[$];
    logic       m_ovf;
    logic [7:0] m_txd;
    bit         m_strobe;      // SEND expected visible after this edge
    bit         m_wait;        // sent, waiting for READY to fall

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance transmitter and reference model,
    // take the edge, then compare all outputs on the falling edge.
    task automatic step();
        logic       rdy;
        bit         pop, was_full, nw_wait;
        rdy = rdy_mode ? (tx_busy == 0 && !tx_init) : rdy_force;
        RESET           = rst;
        bus.IN_WRITE    = wr;
        bus.IN_DATA     = din;
        bus.IN_TX_READY = rdy;

        // transmitter: latches the byte at an edge where SEND and READY are high
        if (bus.OUT_TX_SEND === 1'b1) begin
            if (rdy) begin
                if (exp_sent.size() == 0) chk("tx_unexpected", 32'(bus.OUT_TX_DATA), 32'hxx);
                else chk("tx_byte", 32'(bus.OUT_TX_DATA), 32'(exp_sent.pop_front()));
                tx_busy = tx_frame;
            end else begin
                chk("send_while_not_ready", 32'(rdy), 32'd1);
            end
        end else if (tx_busy > 0) begin
            tx_busy--;
        end
        if (rst) begin
            tx_init = 1'b1;
            tx_busy = 0;
        end else begin
            tx_init = 1'b0;
        end

        // reference model
        if (rst) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_txd    = 8'h00;
            m_strobe = 1'b0;
            m_wait   = 1'b0;
        end else begin
            pop      = !m_strobe && !m_wait && (m_q.size() != 0) && rdy;
            was_full = (m_q.size() == 16);
            nw_wait  = m_strobe ? 1'b1 : (m_wait && rdy);
            m_strobe = pop;
            m_wait   = nw_wait;
            if (pop) begin
                m_txd = m_q.pop_front();
                exp_sent.push_back(m_txd);
            end
            if (wr) begin
                if (was_full) m_ovf = 1'b1;
                else m_q.push_back(din);
            end
        end

        @(posedge CLK);
        @(negedge CLK);
        chk("count",    32'(bus.OUT_COUNT),    32'(m_q.size()));
        chk("empty",    32'(bus.OUT_EMPTY),    32'(m_q.size() == 0));
        chk("full",     32'(bus.OUT_FULL),     32'(m_q.size() == 16));
        chk("overflow", 32'(bus.OUT_OVERFLOW), 32'(m_ovf));
        chk("tx_send",  32'(bus.OUT_TX_SEND),  32'(m_strobe));
        chk("tx_data",  32'(bus.OUT_TX_DATA),  32'(m_txd));
    endtask

    task automatic idle(input int n);
        wr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [7:0] d);
        wr  = 1'b1;
        din = d;
        step();
        wr  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; din = 8'h00; rdy_force = 1'b0; rdy_mode = 1'b0;
        tx_frame = 12; tx_busy = 0; tx_init = 1'b0;
        m_ovf = 1'b0; m_txd = 8'h00; m_strobe = 1'b0; m_wait = 1'b0;
        @(negedge CLK);

        // reset values
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_empty", 32'(bus.OUT_EMPTY), 32'd1);
        chk("rst_txd",   32'(bus.OUT_TX_DATA), 32'h00);

        // single byte with READY tied high: strobe on the second edge after write
        rdy_force = 1'b1;
        push(8'h55);
        chk("lat_edge1", 32'(bus.OUT_TX_SEND), 32'd0);
        step();
        chk("lat_edge2_send", 32'(bus.OUT_TX_SEND), 32'd1);
        chk("lat_edge2_data", 32'(bus.OUT_TX_DATA), 32'h55);
        idle(10);   // READY stays high: no second send
        chk("single_drained", 32'(exp_sent.size()), 32'd0);

        // ordering through the transmitter model
        rdy_mode = 1'b1; tx_frame = 12; tx_busy = tx_frame;
        push(8'h41); push(8'h42); push(8'h43);
        idle(70);
        chk("abc_drained", 32'(exp_sent.size() + m_q.size()), 32'd0);

        // full / overflow with READY held low
        rdy_mode = 1'b0; rdy_force = 1'b0;
        idle(2);
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i == 15) begin
                chk("full_at16",  32'(bus.OUT_FULL),  32'd1);
                chk("count_at16", 32'(bus.OUT_COUNT), 32'd16);
                chk("no_ovf_16",  32'(bus.OUT_OVERFLOW), 32'd0);
            end
        end
        chk("ovf_after17", 32'(bus.OUT_OVERFLOW), 32'd1);
        rdy_mode = 1'b1; tx_frame = 6; tx_busy = 0;
        idle(16 * 12);
        chk("ovf_sticky", 32'(bus.OUT_OVERFLOW), 32'd1);
        chk("ovf_drained", 32'(exp_sent.size() + m_q.size()), 32'd0);

        // simultaneous write+pop at count 5, then 20 bytes total across the wrap
        rdy_mode = 1'b0; rdy_force = 1'b0;
        idle(2);
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        rdy_force = 1'b1;
        push(8'hA5);
        chk("wr_pop_cnt5", 32'(bus.OUT_COUNT), 32'd5);
        rdy_mode = 1'b1; tx_busy = 0;
        begin
            int n = 6;
            for (int c = 0; c < 2000 && n < 20; c++) begin
                wr  = 1'($urandom_range(0, 1));
                din = 8'hA0 + 8'(n);
                if (wr) n++;
                step();
            end
            chk("wrap_all_written", 32'(n), 32'd20);
        end
        idle(20 * 10);
        chk("wrap_drained", 32'(exp_sent.size() + m_q.size()), 32'd0);

        // randomized traffic with varying frame lengths
        for (int blk = 0; blk < 4; blk++) begin
            tx_frame = $urandom_range(2, 10);
            for (int c = 0; c < 150; c++) begin
                wr  = ($urandom_range(0, 99) < 30);
                din = 8'($urandom);
                step();
            end
        end
        idle(16 * 14);
        chk("rand_drained", 32'(exp_sent.size() + m_q.size()), 32'd0);

        // reset in WAIT_LOW with 4 bytes queued
        rdy_mode = 1'b0; rdy_force = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        idle(2);
        chk("queued4", 32'(bus.OUT_COUNT), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_count", 32'(bus.OUT_COUNT), 32'd0);
        chk("rst_mid_empty", 32'(bus.OUT_EMPTY), 32'd1);
        exp_sent.delete();   // the byte already popped before reset is gone
        idle(20);            // model expects no SEND
        push(8'h7E);
        idle(4);
        chk("post_rst_sent", 32'(exp_sent.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
